// File: rtl/fpu_addsub_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_addsub_sequencer
//
// Purpose:
//   Sequences one request at a time from a core into an external
//   add/sub/compare floating-point unit. It waits a fixed number of cycles
//   (LAT) for the unit result and then presents a held response to the core.
//   Illegal ops get an immediate error response (quiet NaN) without using
//   the unit.
//
// Parameters:
//   LAT            FPU result latency in clocks after operands are driven
//                  (0..7, larger values are clamped to 7)
//
// Ports:
//   clock          single clock
//   reset          asynchronous, active-low reset
//   req_valid/ready, req_a, req_b, req_op
//                  request channel (op: 00 add, 01 sub, 10 compare, 11 illegal)
//   resp_valid/ready, resp_y, resp_a_hi_b, resp_a_equal_b, resp_err
//                  response channel
//   fpu_a, fpu_b, fpu_sub, fpu_comp
//                  operands and op select to the FPU
//   fpu_y, fpu_a_hi_b, fpu_a_equal_b
//                  FPU results
//
// Configuration macro:
//   FPU_SEQ_BYPASS_EN  when defined, a new request may be accepted in the
//                      same cycle as the response handshake (RESP->BUSY or
//                      RESP->RESP), saving the idle cycle between operations.
// ---------------------------------------------------------------------------
module fpu_addsub_sequencer #(
    parameter int LAT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_y,
    output logic        resp_a_hi_b,
    output logic        resp_a_equal_b,
    output logic        resp_err,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_sub,
    output logic        fpu_comp,
    input  logic [31:0] fpu_y,
    input  logic        fpu_a_hi_b,
    input  logic        fpu_a_equal_b
);

    // Counter load value; latencies beyond the 3-bit counter saturate at 7.
    localparam logic [2:0] LAT_LOAD = (LAT > 7) ? 3'd7 : 3'(LAT);

    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_COMP = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [2:0]  r_cnt;
    logic [31:0] r_y;
    logic        r_hi;
    logic        r_eq;
    logic        r_err;

    logic        w_accept;
    logic        w_respFire;
    logic        w_illegal;
    logic        w_capture;

    assign w_accept   = req_valid & req_ready;
    assign w_respFire = resp_valid & resp_ready;
    assign w_illegal  = (req_op == OP_ILL);
    // The FPU result is sampled on the edge where the wait counter has run out.
    assign w_capture  = (r_state == BUSY) && (r_cnt == 3'd0);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. An accept in RESP is only possible with the bypass
    // enabled, and it takes priority over returning to IDLE.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_illegal ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 3'd0) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (w_accept) begin
                    w_nextState = w_illegal ? RESP : BUSY;
                end else if (w_respFire) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        resp_valid = (r_state == RESP);
`ifdef FPU_SEQ_BYPASS_EN
        req_ready  = (r_state == IDLE) || ((r_state == RESP) && resp_ready);
`else
        req_ready  = (r_state == IDLE);
`endif
    end

    // Operand registers and latency counter. Operands stay put for the whole
    // operation so the FPU sees stable inputs until its result is captured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= req_a;
                r_b   <= req_b;
                r_op  <= req_op;
                r_cnt <= LAT_LOAD;
            end else if ((r_state == BUSY) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Result registers. They only change on capture or on an illegal-op
    // accept, which keeps the response stable while the core stalls it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_y   <= '0;
            r_hi  <= 1'b0;
            r_eq  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_accept && w_illegal) begin
                r_y   <= 32'h7FC0_0000;
                r_hi  <= 1'b0;
                r_eq  <= 1'b0;
                r_err <= 1'b1;
            end else if (w_capture) begin
                r_err <= 1'b0;
                if (r_op == OP_COMP) begin
                    r_y  <= 32'h0000_0000;
                    r_hi <= fpu_a_hi_b;
                    r_eq <= fpu_a_equal_b;
                end else begin
                    r_y  <= fpu_y;
                    r_hi <= 1'b0;
                    r_eq <= 1'b0;
                end
            end
        end
    end

    assign fpu_a          = r_a;
    assign fpu_b          = r_b;
    assign fpu_sub        = (r_op == OP_SUB);
    assign fpu_comp       = (r_op == OP_COMP);
    assign resp_y         = r_y;
    assign resp_a_hi_b    = r_hi;
    assign resp_a_equal_b = r_eq;
    assign resp_err       = r_err;

endmodule

// File: doc/fpu_addsub_sequencer.md
FPU_ADDSUB_SEQUENCER -- requirements
Module: fpu_addsub_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 0, meaning FPU result latency in clock cycles after the operands are driven (legal range 0..7).
REQ-002 SHALL have port clock  input  1  single clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core request valid.
REQ-005 SHALL have port req_ready  output  1  sequencer accepts request.
REQ-006 SHALL have port req_a  input  32  IEEE-754 single operand A.
REQ-007 SHALL have port req_b  input  32  IEEE-754 single operand B.
REQ-008 SHALL have port req_op  input  2  00 add, 01 sub, 10 compare, 11 illegal.
REQ-009 SHALL have port resp_valid  output  1  response valid.
REQ-010 SHALL have port resp_ready  input  1  core accepts response.
REQ-011 SHALL have port resp_y  output  32  result word.
REQ-012 SHALL have port resp_a_hi_b  output  1  compare result A>B.
REQ-013 SHALL have port resp_a_equal_b  output  1  compare result A==B.
REQ-014 SHALL have port resp_err  output  1  illegal-op flag.
REQ-015 SHALL have ports fpu_a, fpu_b  output  32 each  operands to the add/sub/compare unit.
REQ-016 SHALL have ports fpu_sub, fpu_comp  output  1 each  op select to the unit.
REQ-017 SHALL have ports fpu_y  input  32, fpu_a_hi_b, fpu_a_equal_b  input  1 each  unit results.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, RESP; req_ready=1 only in IDLE (see REQ-031).
REQ-019 SHALL, on req_valid&req_ready at edge E0, register req_a, req_b, req_op into operand registers and load a 3-bit counter with LAT.
REQ-020 SHALL drive fpu_a/fpu_b from the operand registers at all times; fpu_sub=1 only for op 01; fpu_comp=1 only for op 10.
REQ-021 SHALL transition IDLE->BUSY at E0 for ops 00/01/10; in BUSY, decrement the counter each edge while nonzero; at the edge where counter==0, capture FPU outputs and go to RESP.
REQ-022 SHALL therefore assert resp_valid exactly LAT+1 edges after E0 for legal ops.
REQ-023 SHALL, for add/sub, return resp_y=fpu_y and both compare flags 0; for compare, resp_y=32'h00000000 and flags from fpu_a_hi_b/fpu_a_equal_b.
REQ-024 SHALL, for op 11, skip BUSY: go IDLE->RESP at E0 with resp_err=1, resp_y=32'h7FC00000, flags 0; resp_err=0 for legal ops.
REQ-025 SHALL hold all resp_* outputs stable in RESP while resp_ready=0, for any number of cycles.
REQ-026 SHALL leave RESP for IDLE on resp_valid&resp_ready, deasserting resp_valid the following cycle.
REQ-027 SHALL ignore req_valid outside IDLE and ignore resp_ready outside RESP.
REQ-028 SHALL clamp LAT values >7 to 7.

Reset
REQ-029 SHALL, on reset low, asynchronously force state IDLE, counter 0, operand and result registers 0, so resp_valid=0, resp_y=0, flags 0, resp_err=0, fpu_* outputs 0, req_ready=1.
REQ-030 SHALL, on reset mid-BUSY or mid-RESP, discard the in-flight operation with no response produced after reset release.

Configuration
REQ-031 SHALL, when macro FPU_SEQ_BYPASS_EN is defined, also assert req_ready in RESP when resp_ready=1, so that a new request is accepted in the same cycle as the response handshake and the FSM moves RESP->BUSY (or RESP->RESP for op 11) directly; without the macro, req_ready=1 only in IDLE and back-to-back issue costs one extra IDLE cycle.

Verification
REQ-032 SHALL cover, at LAT=0: op 00, a=0x3F800000, b=0x40000000 -> resp_valid 1 edge after accept, resp_y=0x40400000, flags 0, err 0.
REQ-033 SHALL cover op 01, a=0x40400000, b=0x3F800000, LAT=2 -> resp_valid 3 edges after accept, resp_y=0x40000000.
REQ-034 SHALL cover op 10, a=0x40000000, b=0x3F800000 -> resp_y=0, a_hi_b=1, a_equal_b=0; repeat a=b=0x3F800000 -> a_hi_b=0, a_equal_b=1.
REQ-035 SHALL cover op 11 with resp_ready=0 for 5 cycles -> resp_err=1, resp_y=0x7FC00000 held stable, req_ready=0, release after handshake.
REQ-036 SHALL cover reset low during BUSY at LAT=3 -> resp_valid stays 0, req_ready=1 next cycle, no stale response.
REQ-037 SHALL cover two back-to-back adds with resp_ready=1, LAT=0 -> accepts every 2 cycles with FPU_SEQ_BYPASS_EN, every 3 cycles without.
